// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants for the instruction-fetch prefetch stage
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_OFF = 2'b01;
    localparam logic [1:0] PCSRC_RS  = 2'b10;

    // 2'b11 is reserved and behaves as sequential fetch
    function automatic logic is_redirect(input logic [1:0] src);
        return (src == PCSRC_OFF) || (src == PCSRC_RS);
    endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// rtl/if_prefetch_stage_if.sv - instruction-memory request/response bundle
interface if_prefetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and occupancy count
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - fetch stage with prefetch queue, PC ownership and IF/ID register
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         disable_PC,
    input  logic                         disable_IR,
    input  logic                         KILL,
    input  logic [1:0]                   PCsrc,
    input  logic [XLEN-1:0]              PC_offset,
    input  logic [XLEN-1:0]              PC_regRs,
    if_prefetch_stage_if.master          imem,
    output logic [31:0]                  Instruction_F,
    output logic [XLEN-1:0]              NPC_F,
    output logic                         valid_F,
    output logic [XLEN-1:0]              PC,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = 32 + XLEN;

    logic [XLEN-1:0] r_pc;
    logic [IW-1:0]   r_inflight;
    logic [IW-1:0]   r_drop_cnt;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_npc;
    logic            r_valid;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [IW-1:0]   w_live;
    logic            w_issue;
    logic            w_fire;
    logic            w_resp_keep;
    logic            w_pop;
    logic [XLEN-1:0] w_npc_head;
    logic [QW-1:0]   w_q_head;

    assign w_redirect = is_redirect(PCsrc);

    always_comb begin
        w_target = r_pc;
        case (PCsrc)
            PCSRC_SEQ: w_target = r_pc;
            PCSRC_OFF: w_target = PC_offset;
            PCSRC_RS:  w_target = PC_regRs;
            default:   w_target = r_pc;
        endcase
    end

    // Requests not yet answered and not doomed to be dropped each own one
    // NPC FIFO slot, so its count equals inflight - drop_cnt.
    assign w_issue = !reset && !disable_PC && !w_redirect
                   && (r_inflight < IW'(MAX_OUTSTANDING))
                   && ((32'(occupancy) + 32'(w_live)) < 32'(DEPTH));
    assign w_fire      = w_issue && imem.imem_req_ready;
    assign w_resp_keep = imem.imem_resp_valid && (r_drop_cnt == '0) && !w_redirect;
    assign w_pop       = !disable_IR && !KILL && !w_redirect && (occupancy != '0);

    assign imem.imem_req_valid = w_issue;
    assign imem.imem_req_addr  = r_pc;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_npc_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_redirect),
        .i_push      (w_fire),
        .i_push_data (r_pc + XLEN'(1)),
        .i_pop       (w_resp_keep),
        .o_head      (w_npc_head),
        .o_count     (w_live)
    );

    sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_redirect),
        .i_push      (w_resp_keep),
        .i_push_data ({imem.imem_resp_data, w_npc_head}),
        .i_pop       (w_pop),
        .o_head      (w_q_head),
        .o_count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= r_inflight + IW'(w_fire) - IW'(imem.imem_resp_valid);
            if (w_redirect) begin
                r_drop_cnt <= r_inflight - IW'(imem.imem_resp_valid);
            end else if (imem.imem_resp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - IW'(1);
            end
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_fire) begin
                r_pc <= r_pc + XLEN'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP_INSTR;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (!disable_IR) begin
            if (w_pop) begin
                r_instr <= w_q_head[QW-1:XLEN];
                r_npc   <= w_q_head[XLEN-1:0];
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_npc   <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    assign Instruction_F = r_instr;
    assign NPC_F         = r_npc;
    assign valid_F       = r_valid;
    assign PC            = r_pc;

endmodule
